pipe_hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage core. Sits beside the decode stage and drives the stall/bubble/flush

---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the decode-side pipeline and the hazard sequencer.
// The slave side belongs to the sequencer. The master side belongs to the pipeline.
interface pipe_hazard_ctrl_if;
    logic       ID_vld;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic       ID_use_rs1;
    logic       ID_use_rs2;
    logic       ID_is_mul;
    logic       ID_is_break;
    logic       ID_EX_vld;
    logic       ID_EX_load;
    logic [4:0] ID_EX_rd;
    logic       EX_redirect;
    logic       mem_busy;

    logic       stall_if;
    logic       bubble_id;
    logic       stall_ex;
    logic       bubble_ex;
    logic       stall_all;
    logic       flush;
    logic       mul_busy;
    logic       halted;

    modport master (
        output ID_vld, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_is_mul, ID_is_break,
               ID_EX_vld, ID_EX_load, ID_EX_rd, EX_redirect, mem_busy,
        input  stall_if, bubble_id, stall_ex, bubble_ex, stall_all, flush, mul_busy, halted
    );

    modport slave (
        input  ID_vld, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_is_mul, ID_is_break,
               ID_EX_vld, ID_EX_load, ID_EX_rd, EX_redirect, mem_busy,
        output stall_if, bubble_id, stall_ex, bubble_ex, stall_all, flush, mul_busy, halted
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble/flush sequencer for the 5-stage core.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  RUN      | normal issue; resolves redirect, load-use, MUL, EBREAK
//  MUL_WAIT | MUL still occupying EX; front end held, EX/MEM bubbled
//  DRAIN    | EBREAK left ID; older instructions retiring before halt
//  HALT     | core halted; sticky until rst
module pipe_hazard_ctrl #(
    parameter int MUL_LAT   = 3,
    parameter int DRAIN_LAT = 3
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MUL_WAIT, DRAIN, HALT} state_e;

    localparam int CNT_MAX = (MUL_LAT > DRAIN_LAT) ? MUL_LAT : DRAIN_LAT;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] MUL_INIT   = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_LAT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hazard;
    logic          stall_if, bubble_id, stall_ex, bubble_ex;
    logic          stall_all, flush, mul_busy, halted;

    assign hazard = hz.ID_vld & hz.ID_EX_vld & hz.ID_EX_load & (hz.ID_EX_rd != 5'd0)
                  & ((hz.ID_use_rs1 & (hz.ID_rs1 == hz.ID_EX_rd))
                   | (hz.ID_use_rs2 & (hz.ID_rs2 == hz.ID_EX_rd)));

    // Next-state and control decode. A memory wait freezes state and count in every state except HALT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_if  = 1'b0;
        bubble_id = 1'b0;
        stall_ex  = 1'b0;
        bubble_ex = 1'b0;
        stall_all = 1'b0;
        flush     = 1'b0;
        mul_busy  = 1'b0;
        halted    = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (hz.mem_busy) begin
                        stall_all = 1'b1;
                    end else if (hz.EX_redirect) begin
                        flush = 1'b1;
                    end else if (hazard) begin
                        stall_if  = 1'b1;
                        bubble_id = 1'b1;
                    end else if (hz.ID_vld && hz.ID_is_mul) begin
                        // A single-cycle MUL behaves like any other ALU op.
                        if (MUL_LAT > 1) begin
                            state_d = MUL_WAIT;
                            cnt_d   = MUL_INIT;
                        end
                    end else if (hz.ID_vld && hz.ID_is_break) begin
                        stall_if = 1'b1;
                        state_d  = DRAIN;
                        cnt_d    = DRAIN_INIT;
                    end
                end
                MUL_WAIT: begin
                    mul_busy = 1'b1;
                    if (hz.mem_busy) begin
                        stall_all = 1'b1;
                    end else begin
                        stall_if  = 1'b1;
                        stall_ex  = 1'b1;
                        bubble_ex = 1'b1;
                        cnt_d     = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (hz.mem_busy) begin
                        stall_all = 1'b1;
                    end else begin
                        stall_if  = 1'b1;
                        bubble_id = 1'b1;
                        cnt_d     = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) state_d = HALT;
                    end
                end
                HALT: begin
                    halted    = 1'b1;
                    stall_if  = 1'b1;
                    bubble_id = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stall_if  = stall_if;
    assign hz.bubble_id = bubble_id;
    assign hz.stall_ex  = stall_ex;
    assign hz.bubble_ex = bubble_ex;
    assign hz.stall_all = stall_all;
    assign hz.flush     = flush;
    assign hz.mul_busy  = mul_busy;
    assign hz.halted    = halted;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random cycles,
// every cycle compared against a cycle-count model of the sequencing rules.
module tb_pipe_hazard_ctrl;
    localparam int MUL_LAT   = 3;
    localparam int DRAIN_LAT = 3;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mul;
        logic       brk;
        logic       exv;
        logic       exld;
        logic [4:0] exrd;
        logic       redir;
        logic       mb;
    } stim_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    // Model: remaining MUL wait cycles, remaining drain cycles, halted flag.
    int   mul_left;
    int   drain_left;
    bit   halt_m;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DRAIN_LAT(DRAIN_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, compare outputs mid-cycle, advance the model at the edge.
    // Output vector order: stall_if bubble_id stall_ex bubble_ex stall_all flush mul_busy halted
    task automatic apply(input stim_t s, input string tag);
        logic [7:0] exp_v;
        logic [7:0] got;
        int         n_mul;
        int         n_drain;
        bit         n_halt;
        bit         hz_m;
        rst             = s.rst;
        bus.ID_vld      = s.vld;
        bus.ID_rs1      = s.rs1;
        bus.ID_rs2      = s.rs2;
        bus.ID_use_rs1  = s.u1;
        bus.ID_use_rs2  = s.u2;
        bus.ID_is_mul   = s.mul;
        bus.ID_is_break = s.brk;
        bus.ID_EX_vld   = s.exv;
        bus.ID_EX_load  = s.exld;
        bus.ID_EX_rd    = s.exrd;
        bus.EX_redirect = s.redir;
        bus.mem_busy    = s.mb;
        @(negedge clk);
        exp_v   = 8'b0;
        n_mul   = mul_left;
        n_drain = drain_left;
        n_halt  = halt_m;
        hz_m = s.vld && s.exv && s.exld && (s.exrd != 0)
            && ((s.u1 && s.rs1 == s.exrd) || (s.u2 && s.rs2 == s.exrd));
        if (s.rst) begin
            n_mul = 0; n_drain = 0; n_halt = 0;
        end else if (halt_m) begin
            exp_v = 8'b1100_0001;
        end else if (s.mb) begin
            exp_v = (mul_left > 0) ? 8'b0000_1010 : 8'b0000_1000;
        end else if (mul_left > 0) begin
            exp_v = 8'b1011_0010;
            n_mul = mul_left - 1;
        end else if (drain_left > 0) begin
            exp_v   = 8'b1100_0000;
            n_drain = drain_left - 1;
            if (n_drain == 0) n_halt = 1;
        end else if (s.redir) begin
            exp_v = 8'b0000_0100;
        end else if (hz_m) begin
            exp_v = 8'b1100_0000;
        end else if (s.vld && s.mul) begin
            n_mul = MUL_LAT - 1;
        end else if (s.vld && s.brk) begin
            exp_v   = 8'b1000_0000;
            n_drain = DRAIN_LAT;
        end
        got = {bus.stall_if, bus.bubble_id, bus.stall_ex, bus.bubble_ex,
               bus.stall_all, bus.flush, bus.mul_busy, bus.halted};
        vectors++;
        assert (got === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp_v);
        end
        @(posedge clk);
        mul_left   = n_mul;
        drain_left = n_drain;
        halt_m     = n_halt;
        #1;
    endtask

    initial begin
        stim_t s;
        stim_t idle;
        vectors     = 0;
        miscompares = 0;
        mul_left    = 0;
        drain_left  = 0;
        halt_m      = 0;
        idle        = '0;

        s = idle; s.rst = 1'b1;
        apply(s, "reset0");
        apply(s, "reset1");
        apply(idle, "idle");

        // T1 load-use: lw x5 in EX, add x6,x5,x1 in ID
        s = idle; s.vld = 1; s.rs1 = 5; s.rs2 = 1; s.u1 = 1; s.u2 = 1;
        s.exv = 1; s.exld = 1; s.exrd = 5;
        apply(s, "t1_hazard");
        s.exv = 0; s.exld = 0; s.exrd = 0;
        apply(s, "t1_issue");
        s = idle; s.vld = 1; s.rs1 = 0; s.u1 = 1; s.exv = 1; s.exld = 1; s.exrd = 0;
        apply(s, "t1_x0");
        s = idle; s.vld = 1; s.rs2 = 7; s.u2 = 1; s.exv = 1; s.exld = 1; s.exrd = 7;
        apply(s, "t1_rs2");

        // T2 MUL occupancy
        s = idle; s.vld = 1; s.mul = 1;
        apply(s, "t2_issue");
        apply(s, "t2_wait1");
        apply(s, "t2_wait2");
        apply(idle, "t2_run");

        // T3 MUL wait frozen by memory
        s = idle; s.vld = 1; s.mul = 1;
        apply(s, "t3_issue");
        apply(idle, "t3_wait1");
        s = idle; s.mb = 1;
        for (int i = 0; i < 4; i++) apply(s, "t3_membusy");
        apply(idle, "t3_wait2");
        apply(idle, "t3_run");

        // T4 redirect beats hazard and MUL
        s = idle; s.vld = 1; s.mul = 1; s.rs1 = 3; s.u1 = 1;
        s.exv = 1; s.exld = 1; s.exrd = 3; s.redir = 1;
        apply(s, "t4_redirect");
        apply(idle, "t4_run");

        // T5 EBREAK drain then halt, memory wait ignored while halted
        s = idle; s.vld = 1; s.brk = 1;
        apply(s, "t5_issue");
        for (int i = 0; i < DRAIN_LAT; i++) apply(idle, "t5_drain");
        apply(idle, "t5_halt");
        s = idle; s.mb = 1; s.redir = 1;
        apply(s, "t5_halt_mb");

        // T6 reset during HALT and during MUL_WAIT
        s = idle; s.rst = 1;
        apply(s, "t6_rst_halt");
        apply(idle, "t6_run");
        s = idle; s.vld = 1; s.mul = 1;
        apply(s, "t6_mul");
        s = idle; s.rst = 1;
        apply(s, "t6_rst_mul");
        apply(idle, "t6_run2");
        s = idle; s.vld = 1; s.mul = 1;
        apply(s, "t6_mul2");
        apply(idle, "t6_wait");

        // Random traffic over a small register range so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            s       = idle;
            s.rst   = ($urandom_range(0, 99) < 3);
            s.vld   = ($urandom_range(0, 3) != 0);
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.u1    = $urandom_range(0, 1) == 1;
            s.u2    = $urandom_range(0, 1) == 1;
            s.mul   = ($urandom_range(0, 99) < 20);
            s.brk   = ($urandom_range(0, 99) < 4);
            s.exv   = $urandom_range(0, 1) == 1;
            s.exld  = $urandom_range(0, 1) == 1;
            s.exrd  = 5'($urandom_range(0, 3));
            s.redir = ($urandom_range(0, 99) < 10);
            s.mb    = ($urandom_range(0, 99) < 15);
            apply(s, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
